th_frame_rx: RTL and testbench

TH_FRAME_RX -- requirements
Module: th_frame_rx

---
 rtl/th_pkg.sv | 26 ++
 rtl/th_timeout_cnt.sv | 32 +++
 rtl/th_frame_rx.sv | 164 ++++++++++++++++
 tb/tb_th_frame_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/th_pkg.sv
// Shared types and constants for the temperature/humidity frame receiver.
// Optional feature macro: TH_FRAME_CHK_EN (adds a third, checksum byte).
package th_pkg;

  // Default timeouts, in clock cycles.
  localparam int DEF_BYTE_TIMEOUT  = 67108864;
  localparam int DEF_STALE_TIMEOUT = 134217728;

  // Frame assembly states; GOT_HUM exists only when the checksum byte is expected.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_TEMP = 2'd1
`ifdef TH_FRAME_CHK_EN
    ,
    ST_GOT_HUM  = 2'd2
`endif
  } th_state_e;

`ifdef TH_FRAME_CHK_EN
  // Checksum byte is the 8-bit sum of temperature and humidity.
  function automatic logic [7:0] th_checksum(input logic [7:0] temp, input logic [7:0] hum);
    return temp + hum;
  endfunction
`endif

endpackage

// File: rtl/th_timeout_cnt.sv
// Clear/enable up-counter that saturates at MAX_COUNT and flags TC_VALUE.
// Width is sized so the counter can hold MAX_COUNT without wrapping.
module th_timeout_cnt #(
  parameter int MAX_COUNT = 16,
  parameter int TC_VALUE  = MAX_COUNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(MAX_COUNT + 1);

  logic [W-1:0] count;

  // Count register: clear wins over enable, holds once saturated.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != W'(MAX_COUNT))) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TC_VALUE));

endmodule

// File: rtl/th_frame_rx.sv
// Assembles temperature/humidity frames from a UART byte stream, with an
// inter-byte timeout and a stale-data indicator.
// Optional feature macro: TH_FRAME_CHK_EN (third byte = temp + hum mod 256).
module th_frame_rx
  import th_pkg::*;
#(
  parameter int BYTE_TIMEOUT  = DEF_BYTE_TIMEOUT,
  parameter int STALE_TIMEOUT = DEF_STALE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD_data_ready,
  input  logic [7:0] RxD_data,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic       data_valid,
  output logic       frame_err,
  output logic       stale
);

  th_state_e  state, next_state;
  logic [7:0] pend_temp;
  logic [7:0] commit_hum;
  logic       ld_temp, commit, discard;
  logic       byte_tc, stale_tc;
  logic       never_committed;
`ifdef TH_FRAME_CHK_EN
  logic [7:0] pend_hum;
  logic       ld_hum;
  logic       chk_ok;

  assign chk_ok     = (RxD_data == th_checksum(pend_temp, pend_hum));
  assign commit_hum = pend_hum;
`else
  assign commit_hum = RxD_data;
`endif

  // Inter-byte timer: held clear in IDLE and on every accepted byte.
  th_timeout_cnt #(
    .MAX_COUNT (BYTE_TIMEOUT),
    .TC_VALUE  (BYTE_TIMEOUT - 1)
  ) u_byte_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (RxD_data_ready || (state == ST_IDLE)),
    .en    (state != ST_IDLE),
    .tc    (byte_tc)
  );

  // Stale timer: restarts on each commit, otherwise runs up to saturation.
  th_timeout_cnt #(
    .MAX_COUNT (STALE_TIMEOUT),
    .TC_VALUE  (STALE_TIMEOUT)
  ) u_stale_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (commit),
    .en    (1'b1),
    .tc    (stale_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: advance on each byte, fall back to IDLE on frame end or timeout.
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (RxD_data_ready) next_state = ST_GOT_TEMP;
      end
      ST_GOT_TEMP: begin
`ifdef TH_FRAME_CHK_EN
        if (RxD_data_ready) next_state = ST_GOT_HUM;
`else
        if (RxD_data_ready) next_state = ST_IDLE;
`endif
        else if (byte_tc)   next_state = ST_IDLE;
      end
`ifdef TH_FRAME_CHK_EN
      ST_GOT_HUM: begin
        if (RxD_data_ready || byte_tc) next_state = ST_IDLE;
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode: which pending byte to latch, and whether to commit or discard.
  always_comb begin
    ld_temp = 1'b0;
    commit  = 1'b0;
    discard = 1'b0;
`ifdef TH_FRAME_CHK_EN
    ld_hum  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        ld_temp = RxD_data_ready;
      end
      ST_GOT_TEMP: begin
`ifdef TH_FRAME_CHK_EN
        if (RxD_data_ready) ld_hum = 1'b1;
`else
        if (RxD_data_ready) commit = 1'b1;
`endif
        else if (byte_tc)   discard = 1'b1;
      end
`ifdef TH_FRAME_CHK_EN
      ST_GOT_HUM: begin
        if (RxD_data_ready) begin
          commit  = chk_ok;
          discard = !chk_ok;
        end else if (byte_tc) begin
          discard = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Pending byte holding registers; never visible until a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_temp <= '0;
`ifdef TH_FRAME_CHK_EN
      pend_hum  <= '0;
`endif
    end else begin
      if (ld_temp) pend_temp <= RxD_data;
`ifdef TH_FRAME_CHK_EN
      if (ld_hum)  pend_hum  <= RxD_data;
`endif
    end
  end

  // Output registers: load on commit, one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temperature     <= '0;
      humidity        <= '0;
      data_valid      <= 1'b0;
      frame_err       <= 1'b0;
      never_committed <= 1'b1;
    end else begin
      data_valid <= commit;
      frame_err  <= discard;
      if (commit) begin
        temperature     <= pend_temp;
        humidity        <= commit_hum;
        never_committed <= 1'b0;
      end
    end
  end

  // Stale until the first commit, and again once the stale timer saturates.
  assign stale = never_committed || stale_tc;

endmodule

// File: tb/tb_th_frame_rx.sv
// Self-checking bench for th_frame_rx with short timeouts (16 / 32 cycles).
// Build with TH_FRAME_CHK_EN defined to exercise the checksum frame format.
module tb_th_frame_rx;

  localparam int BT = 16;
  localparam int ST = 32;
`ifdef TH_FRAME_CHK_EN
  localparam int FRAME_LEN = 3;
`else
  localparam int FRAME_LEN = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] temperature, humidity;
  logic       data_valid, frame_err, stale;

  always #5 clk = ~clk;

  th_frame_rx #(
    .BYTE_TIMEOUT  (BT),
    .STALE_TIMEOUT (ST)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RxD_data_ready (rdy),
    .RxD_data       (data),
    .temperature    (temperature),
    .humidity       (humidity),
    .data_valid     (data_valid),
    .frame_err      (frame_err),
    .stale          (stale)
  );

  int    checks = 0;
  int    failures = 0;
  string phase = "init";

  // Reference model: bytes of the frame in progress, idle gap, commit history.
  logic [7:0] frame_q[$];
  int         gap = 0;
  int         since = 0;
  bit         ever = 1'b0;
  logic [7:0] exp_t = 8'h00;
  logic [7:0] exp_h = 8'h00;
  logic       exp_dv = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_stale = 1'b1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("temperature", temperature, exp_t);
    check("humidity", humidity, exp_h);
    check("data_valid", {7'd0, data_valid}, {7'd0, exp_dv});
    check("frame_err", {7'd0, frame_err}, {7'd0, exp_fe});
    check("stale", {7'd0, stale}, {7'd0, exp_stale});
  endtask

  task automatic model_reset();
    frame_q.delete();
    gap = 0;
    since = 0;
    ever = 1'b0;
    exp_t = 8'h00;
    exp_h = 8'h00;
    exp_dv = 1'b0;
    exp_fe = 1'b0;
    exp_stale = 1'b1;
  endtask

  // Expected outputs after one rising edge with the given inputs.
  task automatic model_edge(input logic r, input logic [7:0] d);
    bit fire;
`ifdef TH_FRAME_CHK_EN
    logic [7:0] sum;
`endif
    fire = 1'b0;
    exp_dv = 1'b0;
    exp_fe = 1'b0;
    if (r) begin
      frame_q.push_back(d);
      gap = 0;
      if (frame_q.size() == FRAME_LEN) begin
`ifdef TH_FRAME_CHK_EN
        sum = 8'(frame_q[0] + frame_q[1]);
        if (sum == frame_q[2]) fire = 1'b1;
        else                   exp_fe = 1'b1;
`else
        fire = 1'b1;
`endif
        if (fire) begin
          exp_t = frame_q[0];
          exp_h = frame_q[1];
          exp_dv = 1'b1;
        end
        frame_q.delete();
      end
    end else if (frame_q.size() != 0) begin
      gap++;
      if (gap >= BT) begin
        exp_fe = 1'b1;
        frame_q.delete();
      end
    end
    if (fire) begin
      ever = 1'b1;
      since = 0;
    end else if (since < ST) begin
      since++;
    end
    exp_stale = !ever || (since >= ST);
  endtask

  // One clock: drive at negedge, model at posedge, check at the next negedge.
  task automatic cycle(input logic r, input logic [7:0] d);
    rdy = r;
    data = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] h, input int g);
    send_byte(t);
    idle(g);
    send_byte(h);
`ifdef TH_FRAME_CHK_EN
    idle(g);
    send_byte(8'(t + h));
`endif
  endtask

  task automatic do_reset(input int hold);
    rdy = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    phase = "reset";
    @(negedge clk);
    do_reset(2);

    // Byte in the first clock after reset, then a pair 5 cycles apart.
    phase = "basic_19_3c";
    send_frame(8'h19, 8'h3C, 4);
    idle(2);

    // Lone byte times out, then a good pair.
    phase = "timeout";
    send_byte(8'h20);
    idle(20);
    send_frame(8'h21, 8'h40, 1);

    // Next byte on cycle 15 after the previous one.
    phase = "gap15";
    send_byte(8'h55);
    idle(14);
    send_byte(8'hAA);
`ifdef TH_FRAME_CHK_EN
    idle(14);
    send_byte(8'hFF);
`endif

    // Next byte coincident with the timeout cycle: accepted, no error.
    phase = "gap16";
    send_byte(8'h66);
    idle(15);
    send_byte(8'h77);
`ifdef TH_FRAME_CHK_EN
    idle(15);
    send_byte(8'hDD);
`endif

    // One cycle too late: error, late byte starts a new frame.
    phase = "gap17";
    send_byte(8'h01);
    idle(16);
    send_byte(8'h02);
    send_byte(8'h03);
    idle(20);

`ifdef TH_FRAME_CHK_EN
    phase = "checksum";
    send_byte(8'h19);
    send_byte(8'h3C);
    send_byte(8'h55);
    idle(3);
    send_byte(8'h19);
    send_byte(8'h3C);
    send_byte(8'h56);
    idle(3);
`endif

    phase = "back_to_back";
    send_frame(8'hA5, 8'h5A, 0);
    send_frame(8'h0F, 8'hF0, 0);

    // Reset mid-frame drops the pending byte silently.
    phase = "mid_reset";
    send_byte(8'h33);
    idle(2);
    @(negedge clk);
    do_reset(1);
    send_frame(8'h11, 8'h22, 2);

    phase = "stale";
    idle(40);
    send_frame(8'h44, 8'h88, 3);
    idle(35);

    phase = "random";
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_frame(8'($urandom), 8'($urandom), $urandom_range(0, 16));
      end else begin
        send_byte(8'($urandom));
      end
      idle($urandom_range(0, 18));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
